// File: rtl/ram_frame_reader_pkg.sv
// Shared types, FIFO sizing and the bit-reverse helper for ram_frame_reader.
// bitrev() is only called when FRAME_READER_BITREV_EN is defined.
package ram_frame_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int FIFO_DEPTH   = 4;
  localparam int FIFO_PTR_W   = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int BITREV_MAX_W = 16;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] v,
                                                     input int w);
    logic [BITREV_MAX_W-1:0] src;
    logic [BITREV_MAX_W-1:0] res;
    src = v;
    res = '0;
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      if (i < w) begin
        res = {res[BITREV_MAX_W-2:0], src[0]};
        src = {1'b0, src[BITREV_MAX_W-1:1]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_frame_reader_fifo.sv
// Four-entry synchronous data FIFO with occupancy count; push and pop may
// happen in the same cycle. The head word is read straight from the storage.
module ram_frame_reader_fifo
  import ram_frame_reader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic                  pop_i,
  output logic [DATA_W-1:0]     data_o,
  output logic [FIFO_CNT_W-1:0] count_o
);

  logic [DATA_W-1:0]     mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q;
  logic [FIFO_PTR_W-1:0] rd_ptr_q;
  logic [FIFO_CNT_W-1:0] count_q;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign push_ok_s = push_i && (count_q != FIFO_CNT_W'(FIFO_DEPTH));
  assign pop_ok_s  = pop_i && (count_q != '0);

  // Storage, pointers and count; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + FIFO_PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + FIFO_PTR_W'(1);
      end
      count_q <= count_q + FIFO_CNT_W'(push_ok_s) - FIFO_CNT_W'(pop_ok_s);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ram_frame_reader.sv
// Frame reader: fetches FRAME_LEN words from the sample RAM and streams them with sop/eop.
// Define FRAME_READER_BITREV_EN to fetch in bit-reversed index order.
module ram_frame_reader
  import ram_frame_reader_pkg::*;
#(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 32,
  parameter int FRAME_LEN    = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk_50mhz_clk,
  input  logic                reset_reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_clken,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_sop,
  output logic                out_eop
);

  localparam int               IDX_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_e                  state_q;
  logic [ADDR_W-1:0]       base_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [ADDR_W-1:0]       addr_d;
  logic [ADDR_W-1:0]       issue_base_s;
  logic [IDX_W-1:0]        idx_q;
  logic [IDX_W-1:0]        issue_idx_s;
  logic [IDX_W-1:0]        out_cnt_q;
  logic                    cs_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    issue_d;
  logic [READ_LATENCY-1:0] vld_q;
  logic [FIFO_CNT_W-1:0]   occ_q;
  logic [FIFO_CNT_W-1:0]   occ_after_pop_s;
  logic [FIFO_CNT_W-1:0]   fifo_count_s;
  logic [DATA_W-1:0]       fifo_data_s;
  logic                    pop_s;
  logic                    push_s;
  logic                    credit_ok_s;
  logic                    valid_s;
  logic                    eop_s;

  function automatic logic [IDX_W-1:0] map_idx(input logic [IDX_W-1:0] idx);
`ifdef FRAME_READER_BITREV_EN
    return IDX_W'(bitrev(BITREV_MAX_W'(idx), IDX_W));
`else
    return idx;
`endif
  endfunction

  // occ_q counts every read from its issue decision until its word leaves the
  // FIFO, so it bounds inflight + fifo_count and the FIFO can never overflow.
  assign valid_s         = (fifo_count_s != '0);
  assign pop_s           = valid_s && out_ready;
  assign push_s          = vld_q[READ_LATENCY-1];
  assign eop_s           = valid_s && (out_cnt_q == LAST_IDX);
  assign occ_after_pop_s = occ_q - FIFO_CNT_W'(pop_s);
  assign credit_ok_s     = (occ_after_pop_s < FIFO_CNT_W'(FIFO_DEPTH));

  // Next-cycle read decision and its address.
  always_comb begin
    issue_d      = 1'b0;
    issue_base_s = base_q;
    issue_idx_s  = idx_q;
    case (state_q)
      IDLE: begin
        issue_d      = start;
        issue_base_s = base_addr;
        issue_idx_s  = '0;
      end
      ISSUE:   issue_d = credit_ok_s;
      DRAIN:   issue_d = 1'b0;
      default: issue_d = 1'b0;
    endcase
    addr_d = issue_base_s + ADDR_W'(map_idx(issue_idx_s));
  end

  // Frame FSM with registered busy/done and RAM command outputs.
  always_ff @(posedge clk_50mhz_clk) begin
    if (reset_reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      idx_q   <= '0;
      cs_q    <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cs_q   <= issue_d;
      if (issue_d) begin
        addr_q <= addr_d;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ISSUE;
            base_q  <= base_addr;
            idx_q   <= IDX_W'(1);
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue_d) begin
            idx_q <= idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop_s && eop_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read-return tracking, credit count and output word counter.
  always_ff @(posedge clk_50mhz_clk) begin
    if (reset_reset) begin
      vld_q     <= '0;
      occ_q     <= '0;
      out_cnt_q <= '0;
    end else begin
      vld_q <= READ_LATENCY'({vld_q, cs_q});
      occ_q <= occ_after_pop_s + FIFO_CNT_W'(issue_d);
      if ((state_q == IDLE) && start) begin
        out_cnt_q <= '0;
      end else if (pop_s) begin
        out_cnt_q <= out_cnt_q + IDX_W'(1);
      end else begin
        out_cnt_q <= out_cnt_q;
      end
    end
  end

  ram_frame_reader_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i   (clk_50mhz_clk),
    .rst_i   (reset_reset),
    .push_i  (push_s),
    .data_i  (mem_readdata),
    .pop_i   (pop_s),
    .data_o  (fifo_data_s),
    .count_o (fifo_count_s)
  );

  assign busy           = busy_q;
  assign done           = done_q;
  assign mem_address    = addr_q;
  assign mem_chipselect = cs_q;
  assign mem_clken      = 1'b1;
  assign mem_write      = 1'b0;
  assign mem_writedata  = '0;
  assign mem_byteenable = '1;
  assign out_valid      = valid_s;
  assign out_data       = fifo_data_s;
  assign out_sop        = valid_s && (out_cnt_q == '0);
  assign out_eop        = eop_s;

endmodule

// File: tb/tb_ram_frame_reader.sv
// Directed bench for ram_frame_reader (FRAME_LEN=8, READ_LATENCY=2) with a
// two-cycle RAM model whose word at address a is a.
module tb_ram_frame_reader;

  localparam int ADDR_W       = 11;
  localparam int DATA_W       = 32;
  localparam int FRAME_LEN    = 8;
  localparam int READ_LATENCY = 2;

  logic                clk = 1'b0;
  logic                reset_reset = 1'b1;
  logic                start = 1'b0;
  logic                out_ready = 1'b1;
  logic [ADDR_W-1:0]   base_addr = '0;
  logic                busy, done, mem_chipselect, mem_clken, mem_write;
  logic                out_valid, out_sop, out_eop;
  logic [ADDR_W-1:0]   mem_address;
  logic [DATA_W-1:0]   mem_writedata, mem_readdata, out_data, ram_p1;
  logic [DATA_W/8-1:0] mem_byteenable;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [ADDR_W-1:0] addr_q[$];
  logic [DATA_W-1:0] dat_q[$];
  logic [1:0]        flag_q[$];
  int                xfer_cyc[$];
  int done_cnt, done_cyc, busy_at_done, busy_rise, first_cs, stall_err, max_out;
  logic prev_valid = 1'b0, prev_ready = 1'b0, prev_busy = 1'b0;
  logic [DATA_W+1:0] prev_word = '0;

  ram_frame_reader #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .FRAME_LEN    (FRAME_LEN),
    .READ_LATENCY (READ_LATENCY)
  ) dut (
    .clk_50mhz_clk  (clk),
    .reset_reset    (reset_reset),
    .start          (start),
    .base_addr      (base_addr),
    .busy           (busy),
    .done           (done),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_clken      (mem_clken),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .mem_readdata   (mem_readdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_sop        (out_sop),
    .out_eop        (out_eop)
  );

  always #5 clk = ~clk;

  // Two-stage RAM: data valid two cycles after the address cycle, poison when unselected.
  always @(posedge clk) begin
    ram_p1       <= mem_chipselect ? {21'd0, mem_address} : 32'hDEAD_BEEF;
    mem_readdata <= ram_p1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [ADDR_W-1:0] exp_addr(input logic [ADDR_W-1:0] b, input int i);
    logic [2:0] iv;
    logic [2:0] m;
    iv = 3'(i);
`ifdef FRAME_READER_BITREV_EN
    m = {iv[0], iv[1], iv[2]};
`else
    m = iv;
`endif
    return b + {8'd0, m};
  endfunction

  task automatic clear_mon();
    addr_q.delete(); dat_q.delete(); flag_q.delete(); xfer_cyc.delete();
    done_cnt = 0; done_cyc = -1; busy_at_done = -1; busy_rise = -1;
    first_cs = -1; stall_err = 0; max_out = 0;
  endtask

  // Observe the current cycle at the falling edge, then move to just past the next rising edge.
  task automatic step();
    @(negedge clk);
    if (mem_chipselect === 1'b1) begin
      if (addr_q.size() == 0) first_cs = cyc;
      addr_q.push_back(mem_address);
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      dat_q.push_back(out_data);
      flag_q.push_back({out_sop, out_eop});
      xfer_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = int'(busy);
    end
    if (busy === 1'b1 && !prev_busy) busy_rise = cyc;
    if (prev_valid && !prev_ready &&
        ({out_valid, out_sop, out_eop, out_data} !== {1'b1, prev_word})) stall_err++;
    if (addr_q.size() - dat_q.size() > max_out) max_out = addr_q.size() - dat_q.size();
    prev_valid = (out_valid === 1'b1);
    prev_ready = out_ready;
    prev_busy  = (busy === 1'b1);
    prev_word  = {out_sop, out_eop, out_data};
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_frame(input logic [ADDR_W-1:0] b, input bit bp, input int glitch_k,
                           output int t0);
    clear_mon();
    start = 1'b1;
    base_addr = b;
    out_ready = 1'b1;
    t0 = cyc;
    for (int k = 1; k <= 200; k++) begin
      step();
      start = (k == glitch_k);
      base_addr = (k == glitch_k) ? 11'h555 : b;
      out_ready = bp ? ((k % 3) == 0) : 1'b1;
      if (done_cnt != 0) break;
    end
    start = 1'b0;
    out_ready = 1'b1;
    step();
    step();
  endtask

  task automatic check_frame(input string tag, input logic [ADDR_W-1:0] b, input int t0,
                             input bit timed);
    check_eq({tag, " words"}, dat_q.size(), FRAME_LEN);
    check_eq({tag, " reads"}, addr_q.size(), FRAME_LEN);
    check_eq({tag, " done_count"}, done_cnt, 32'd1);
    check_eq({tag, " busy_at_done"}, busy_at_done, 32'd0);
    check_eq({tag, " stall_stable"}, stall_err, 32'd0);
    check_eq({tag, " outstanding_le4"}, 32'(max_out <= 4), 32'd1);
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (i < addr_q.size())
        check_eq($sformatf("%s addr%0d", tag, i), 32'(addr_q[i]), 32'(exp_addr(b, i)));
      if (i < dat_q.size()) begin
        check_eq($sformatf("%s data%0d", tag, i), dat_q[i], {21'd0, exp_addr(b, i)});
        check_eq($sformatf("%s sop_eop%0d", tag, i), 32'(flag_q[i]),
                 32'({i == 0, i == FRAME_LEN - 1}));
      end
    end
    if (timed) begin
      check_eq({tag, " busy_rise"}, busy_rise, t0 + 1);
      check_eq({tag, " first_cs"}, first_cs, t0 + 1);
      check_eq({tag, " done_cycle"}, done_cyc, t0 + FRAME_LEN + READ_LATENCY + 2);
      if (xfer_cyc.size() == FRAME_LEN) begin
        check_eq({tag, " first_word_cycle"}, xfer_cyc[0], t0 + 2 + READ_LATENCY);
        check_eq({tag, " last_word_cycle"}, xfer_cyc[FRAME_LEN-1],
                 t0 + FRAME_LEN + READ_LATENCY + 1);
      end
    end
  endtask

  initial begin
    int t0;
    clear_mon();
    repeat (3) step();
    reset_reset = 1'b0;
    step();
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst done", 32'(done), 32'd0);
    check_eq("rst out_valid", 32'(out_valid), 32'd0);
    check_eq("rst out_sop", 32'(out_sop), 32'd0);
    check_eq("rst out_eop", 32'(out_eop), 32'd0);
    check_eq("rst out_data", out_data, 32'd0);
    check_eq("rst chipselect", 32'(mem_chipselect), 32'd0);
    check_eq("rst address", 32'(mem_address), 32'd0);
    check_eq("const clken", 32'(mem_clken), 32'd1);
    check_eq("const write", 32'(mem_write), 32'd0);
    check_eq("const writedata", mem_writedata, 32'd0);
    check_eq("const byteenable", 32'(mem_byteenable), 32'hF);

    run_frame(11'h010, 1'b0, 0, t0);
    check_frame("lin", 11'h010, t0, 1'b1);

    run_frame(11'h7FE, 1'b0, 0, t0);
    check_frame("wrap", 11'h7FE, t0, 1'b1);

    run_frame(11'h040, 1'b1, 0, t0);
    check_frame("backpressure", 11'h040, t0, 1'b0);

    run_frame(11'h000, 1'b0, 3, t0);
    check_frame("start_while_busy", 11'h000, t0, 1'b1);

    // Abort after the third word, then confirm a clean restart.
    clear_mon();
    start = 1'b1;
    base_addr = 11'h020;
    t0 = cyc;
    step();
    start = 1'b0;
    while (cyc < t0 + 6) step();
    reset_reset = 1'b1;
    step();
    reset_reset = 1'b0;
    check_eq("abort busy", 32'(busy), 32'd0);
    check_eq("abort done", 32'(done), 32'd0);
    check_eq("abort out_valid", 32'(out_valid), 32'd0);
    check_eq("abort out_sop", 32'(out_sop), 32'd0);
    check_eq("abort out_eop", 32'(out_eop), 32'd0);
    check_eq("abort out_data", out_data, 32'd0);
    check_eq("abort chipselect", 32'(mem_chipselect), 32'd0);
    check_eq("abort address", 32'(mem_address), 32'd0);
    check_eq("abort words_before", dat_q.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < dat_q.size())
        check_eq($sformatf("abort data%0d", i), dat_q[i], {21'd0, exp_addr(11'h020, i)});
    end
    repeat (20) step();
    check_eq("abort no_done", done_cnt, 32'd0);
    check_eq("abort idle_valid", 32'(out_valid), 32'd0);
    check_eq("abort idle_busy", 32'(busy), 32'd0);
    check_eq("abort words_after", dat_q.size(), 32'd3);

    run_frame(11'h020, 1'b0, 0, t0);
    check_frame("after_abort", 11'h020, t0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_frame_reader.md
# ram_frame_reader

Bus-master reader for one port of the dual-port FFT sample RAM: on a start pulse it fetches a frame of FRAME_LEN 32-bit words from a base address and streams them out on a valid/ready interface with start/end-of-packet marks. It drives the RAM slave port's address, chipselect, clken, write and byteenable, and consumes its readdata. It sits between the sample RAM and the FFT core input, and it tolerates backpressure from the FFT core.

## Interface
- ADDR_W, 11, RAM word-address width
- DATA_W, 32, RAM data width
- FRAME_LEN, 1024, words per frame; power of two, 2..2^ADDR_W
- READ_LATENCY, 1, RAM readdata latency in cycles after the address cycle; 1 or 2

- clk_50mhz_clk  in  1  sole clock, rising edge
- reset_reset  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse starting a frame read; ignored while busy=1
- base_addr  in  ADDR_W  first word address; sampled on an accepted start
- busy  out  1  high from the cycle after an accepted start until the cycle after done
- done  out  1  one-cycle pulse after the eop word is accepted
- mem_address  out  ADDR_W  RAM word address
- mem_chipselect  out  1  high only on read-issue cycles
- mem_clken  out  1  constant 1
- mem_write  out  1  constant 0
- mem_writedata  out  DATA_W  constant 0
- mem_byteenable  out  DATA_W/8  all ones
- mem_readdata  in  DATA_W  RAM read data
- out_valid  out  1  stream word valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_W  stream word
- out_sop  out  1  high with the first word of a frame
- out_eop  out  1  high with the last word of a frame

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: on start=1, latch base_addr, clear idx, and go to ISSUE.
- ISSUE: a read is issued when inflight + fifo_count < 4. On a read, chipselect=1, mem_address = (base + map(idx)) mod 2^ADDR_W, and idx++.
  - After issuing idx = FRAME_LEN-1, go to DRAIN.
- DRAIN: wait until inflight = 0 and fifo_count = 0 with the eop word accepted, then pulse done and go to IDLE.
- Capture: a valid shift register of READ_LATENCY stages follows each issue. mem_readdata is pushed into a 4-entry FIFO on the stage-out cycle.
- Credit rule: the FIFO can never overflow, so there is no drop path.
- Handshake: a word transfers when out_valid & out_ready. out_data, out_sop and out_eop hold stable while out_valid=1 and out_ready=0.
- sop/eop: derived from an output word counter. sop is set at count 0 and eop at count FRAME_LEN-1, independent of the address mapping.
- Address wrap: base + idx wraps modulo 2^ADDR_W silently.
- A start during busy is ignored and has no effect on the frame in progress.
- Reset mid-frame: state goes to IDLE, the FIFO and inflight counters are flushed, and the frame is abandoned with no done pulse.
- Reset values: busy=0, done=0, out_valid=0, out_sop=0, out_eop=0, out_data=0, mem_chipselect=0, mem_address=0.

## Timing
- Start sampled at cycle 0; busy=1 at cycle 1; first chipselect at cycle 1.
- readdata is captured at cycle 1+READ_LATENCY; out_valid=1 at cycle 2+READ_LATENCY.
- Throughput: with out_ready held at 1, one word per cycle with no bubbles for both READ_LATENCY values.
- done is asserted the cycle after the eop transfer; busy falls in that same cycle.
- Total frame time with out_ready=1: FRAME_LEN + READ_LATENCY + 2 cycles from start to done.

## Configuration
- FRAME_READER_BITREV_EN
  - Defined: map(idx) = bit-reverse of idx over log2(FRAME_LEN) bits. The frame is emitted in bit-reversed order for a decimation-in-time FFT input.
  - Undefined: map(idx) = idx, giving linear order.
- sop/eop placement and timing are identical in both builds.

## Structure
- Package ram_frame_reader_pkg:
  - state enum {IDLE, ISSUE, DRAIN}
  - FIFO_DEPTH=4
  - bitrev function (parameterised by width)
- Sub-module ram_frame_reader_fifo: 4-entry synchronous FIFO carrying data only, with count output and simultaneous push/pop support. It is instantiated once.
- The top level holds the FSM, credit counter, latency shift register and sop/eop counter.

## Test plan
- FRAME_LEN=8, base=0x010, RAM[i]=i, out_ready=1, linear build -> data 0x10..0x17 on consecutive cycles; sop on 0x10, eop on 0x17; done at cycle 8+READ_LATENCY+2.
- BITREV build, FRAME_LEN=8, base=0 -> read addresses 0,4,2,6,1,5,3,7; sop on the word from address 0, eop on the word from address 7.
- Base 0x7FE, FRAME_LEN=4 -> addresses 0x7FE, 0x7FF, 0x000, 0x001.
- out_ready toggled in a 1-on/2-off pattern with READ_LATENCY=2 -> all 8 words delivered in order with no loss or duplication. Data is stable during stalls, and inflight+fifo_count never exceeds 4.
- start pulsed at cycle 3 of a running frame -> ignored; exactly one done per accepted frame.
- reset_reset asserted after the 3rd word -> next-cycle outputs at reset values with no done. A fresh start then produces a complete, correct frame.
